// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// The counter-width helper keeps a one-cycle dwell legal with a 1-bit counter.
package sweep_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} sweep_state_t;

    localparam int N_COMB = 8;
    localparam int IDX_W  = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COMB - 1);

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// Loadable dwell down-counter.
// It holds at zero rather than wrapping, so zero stays asserted until the next load.
module sweep_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks {a,b,c} through 000..111 and captures the gate block's x/y1 outputs into truth tables.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   DRIVE  | abc held, dwell running (auto) or waiting for step (manual)
//   SAMPLE | capture x_in/y_in into the table bit selected by abc
//   DONE   | sweep complete, tables held until the next start
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    output logic [IDX_W-1:0] abc,
    input  logic             x_in,
    input  logic             y_in,
    output logic [N_COMB-1:0] x_table,
    output logic [N_COMB-1:0] y_table,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(TICK_DIV - 1);

    sweep_state_t      r_state;
    sweep_state_t      w_next;
    logic [IDX_W-1:0]  r_abc;
    logic [N_COMB-1:0] r_x_table;
    logic [N_COMB-1:0] r_y_table;
    logic              w_last;
    logic              w_launch;
    logic              w_load;
    logic              w_en;
    logic              w_zero;
    logic              w_capture;
    logic              w_busy;
    logic              w_done;

    assign w_last = (r_abc == LAST_IDX);

    sweep_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (DWELL_LOAD),
        .en       (w_en),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = DRIVE;
            DRIVE:      if (step_mode ? step : w_zero) w_next = SAMPLE;
            SAMPLE:     w_next = w_last ? DONE : DRIVE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_launch  = start && ((r_state == IDLE) || (r_state == DONE));
        w_capture = (r_state == SAMPLE);
        w_load    = w_launch || (w_capture && !w_last);
        w_en      = (r_state == DRIVE) && !step_mode;
        w_busy    = (r_state == DRIVE) || (r_state == SAMPLE);
        w_done    = (r_state == DONE);
    end

    // abc only moves on the SAMPLE-to-DRIVE edge, giving the gate block a full dwell to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abc     <= '0;
            r_x_table <= '0;
            r_y_table <= '0;
        end else if (w_launch) begin
            r_abc     <= '0;
            r_x_table <= '0;
            r_y_table <= '0;
        end else if (w_capture) begin
            r_x_table[r_abc] <= x_in;
            r_y_table[r_abc] <= y_in;
            if (!w_last) r_abc <= r_abc + 1'b1;
        end
    end

    assign abc     = r_abc;
    assign x_table = r_x_table;
    assign y_table = r_y_table;
    assign busy    = w_busy;
    assign done    = w_done;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a TICK_DIV=4 sweeper and a TICK_DIV=1 sweeper, each driving a behavioural gate model.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start4, step4, mode4, const4;
    logic [2:0] abc4;
    logic       x4, y4, busy4, done4;
    logic [7:0] xt4, yt4;

    logic       start1, step1, mode1;
    logic [2:0] abc1;
    logic       x1, y1, busy1, done1;
    logic [7:0] xt1, yt1;

    // gate model: x = (a&b)^~c, y1 = a&b; const4 swaps in x=1, y=0
    assign x4 = const4 ? 1'b1 : ((abc4[2] & abc4[1]) ^ ~abc4[0]);
    assign y4 = const4 ? 1'b0 : (abc4[2] & abc4[1]);
    assign x1 = (abc1[2] & abc1[1]) ^ ~abc1[0];
    assign y1 = abc1[2] & abc1[1];

    truth_table_sweeper #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .step_mode(mode4), .step(step4),
        .abc(abc4), .x_in(x4), .y_in(y4), .x_table(xt4), .y_table(yt4),
        .busy(busy4), .done(done4)
    );

    truth_table_sweeper #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .step_mode(mode1), .step(step1),
        .abc(abc1), .x_in(x1), .y_in(y1), .x_table(xt1), .y_table(yt1),
        .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done4(input string tag);
        int n = 0;
        while (done4 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done_timeout"}, done4, 1);
    endtask

    // auto sweep on dut4 with optional stray start/step pulses at given cycles
    task automatic sweep4_auto(input string tag, input int start_at, input int step_at);
        int abc_cnt [8];
        int cyc;
        int prev;
        bit order_ok;
        foreach (abc_cnt[i]) abc_cnt[i] = 0;
        prev = 0;
        order_ok = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cyc = 1;
        check({tag, "_busy_after_start"}, busy4, 1);
        while (done4 !== 1'b1 && cyc < 100) begin
            if (busy4) begin
                abc_cnt[abc4]++;
                if (int'(abc4) != prev && int'(abc4) != prev + 1) order_ok = 1'b0;
                prev = int'(abc4);
            end
            start4 = (cyc == start_at);
            step4  = (cyc == step_at);
            tick();
            cyc++;
        end
        start4 = 1'b0;
        step4  = 1'b0;
        check({tag, "_done_cycle"}, cyc, 41);
        check({tag, "_busy_at_done"}, busy4, 0);
        check({tag, "_abc_order"}, order_ok, 1);
        foreach (abc_cnt[i]) check($sformatf("%s_abc%0d_len", tag, i), abc_cnt[i], 5);
        check({tag, "_abc_final"}, abc4, 7);
        check({tag, "_x_table"}, xt4, 8'h95);
        check({tag, "_y_table"}, yt4, 8'hC0);
    endtask

    initial begin
        int n;
        int cyc;
        int prev;
        int incs;
        rst_n  = 1'b0;
        start4 = 1'b0; step4 = 1'b0; mode4 = 1'b0; const4 = 1'b0;
        start1 = 1'b0; step1 = 1'b0; mode1 = 1'b0;
        tick();
        tick();
        check("rst_abc", abc4, 0);
        check("rst_tables", {xt4, yt4}, 16'h0000);
        check("rst_flags", {busy4, done4}, 2'b00);
        rst_n = 1'b1;
        tick();

        sweep4_auto("auto", -1, -1);

        // stray start mid-sweep and step in auto mode must not disturb anything
        sweep4_auto("ignore", 12, 2);

        // async reset mid-sweep at abc=3
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (abc4 !== 3'd3 && n < 100) begin
            tick();
            n++;
        end
        check("rst_mid_reach_abc3", abc4, 3);
        check("rst_mid_partial_x", xt4, 8'h05);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_abc", abc4, 0);
        check("rst_mid_tables", {xt4, yt4}, 16'h0000);
        check("rst_mid_flags", {busy4, done4}, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_idle", {busy4, done4}, 2'b00);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("rst_restart_abc", abc4, 0);
        check("rst_restart_busy", busy4, 1);
        wait_done4("rst_restart");
        check("rst_restart_x", xt4, 8'h95);
        check("rst_restart_y", yt4, 8'hC0);

        // manual stepping with random gaps
        mode4  = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 20)) tick();
            check($sformatf("man_hold_abc%0d", i), {busy4, done4, abc4}, {2'b10, 3'(i)});
            step4 = 1'b1;
            tick();
            step4 = 1'b0;
            check($sformatf("man_sample_abc%0d", i), abc4, i);
            tick();
            if (i < 7) check($sformatf("man_next_abc%0d", i), abc4, i + 1);
            else       check("man_done_after_last", {busy4, done4, abc4}, 5'b01111);
        end
        check("man_x_table", xt4, 8'h95);
        check("man_y_table", yt4, 8'hC0);
        mode4 = 1'b0;

        // restart from DONE with a constant model, then with the real one
        const4 = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4("const");
        check("const_x_table", xt4, 8'hFF);
        check("const_y_table", yt4, 8'h00);
        const4 = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("restart_cleared", {xt4, yt4}, 16'h0000);
        wait_done4("restart");
        check("restart_x_table", xt4, 8'h95);
        check("restart_y_table", yt4, 8'hC0);

        // minimum dwell
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("min_done_cycle", cyc, 17);
        check("min_x_table", xt1, 8'h95);
        check("min_y_table", yt1, 8'hC0);

        // mode toggled during a minimum-dwell sweep
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("tog_start_abc", abc1, 0);
        prev = 0;
        incs = 0;
        cyc  = 0;
        while (done1 !== 1'b1 && cyc < 200) begin
            mode1 = (((cyc / 4) % 2) == 1);
            step1 = mode1 && ((cyc % 3) == 0);
            tick();
            cyc++;
            if (int'(abc1) != prev) begin
                check("tog_seq", abc1, prev + 1);
                prev = int'(abc1);
                incs++;
            end
        end
        step1 = 1'b0;
        mode1 = 1'b0;
        check("tog_done", done1, 1);
        check("tog_incs", incs, 7);
        check("tog_x_table", xt1, 8'h95);
        check("tog_y_table", yt1, 8'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Stimulus-and-capture stage for the combinational gate lab block. It drives that block's 3-bit input vector {a,b,c} through all 8 combinations, from 000 to 111. For each combination it waits a programmable dwell time, then samples the block's two outputs into 8-bit truth-table registers. It sits directly upstream of the gate block, feeding a/b/c, and also consumes its outputs x/y1, so the board can show the full truth table on LEDs.

## Interface
- TICK_DIV, default 50_000_000: dwell cycles per combination in auto mode; legal range is at least 1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a sweep from IDLE or DONE; ignored while busy.
- step_mode  in  1  1 = manual stepping; 0 = timer-driven. Sampled every cycle.
- step  in  1  single-cycle pulse; advances DRIVE to SAMPLE when step_mode=1.
- abc  out  3  drives {a,b,c} of the gate block; a is the MSB.
- x_in  in  1  gate block output x.
- y_in  in  1  gate block output y1.
- x_table  out  8  bit i holds x captured with abc=i.
- y_table  out  8  bit i holds y1 captured with abc=i.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  high in DONE.

## Operation
- The FSM has four states: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**
  - On start: clear x_table and y_table, set abc=0, load the dwell counter with TICK_DIV-1, and go to DRIVE.
- **DRIVE**
  - abc is held stable.
  - Auto mode (step_mode=0): the counter decrements each cycle. When it reaches 0, go to SAMPLE.
  - Manual mode (step_mode=1): the counter is frozen. Go to SAMPLE on the cycle step=1.
  - Switching step_mode mid-dwell resumes from the current counter value.
- **SAMPLE** (one cycle)
  - Write x_table[abc] <= x_in and y_table[abc] <= y_in.
  - If abc==7, go to DONE. Otherwise increment abc, reload the counter, and go to DRIVE.
- **DONE**
  - abc, x_table and y_table are held.
  - start restarts the sweep as in IDLE, clearing the tables.
- Pulse handling:
  - start while busy is ignored.
  - step outside DRIVE, or in auto mode, is ignored.
  - start and step in the same cycle in IDLE: start wins, and step is not remembered.
- abc never wraps mid-sweep. It goes 7 to DONE, never 7 to 0.
- Inputs x_in and y_in are treated as synchronous: the gate block is combinational from registered abc.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Asynchronous reset mid-sweep aborts immediately to the reset values; no partial table is retained.
- Auto-mode sweep timing:
  - If start is seen at edge 0, busy=1 from edge 1.
  - Each combination occupies TICK_DIV DRIVE cycles plus 1 SAMPLE cycle.
  - done=1 from edge 1+8*(TICK_DIV+1); busy drops on the same edge.
- abc changes only on the SAMPLE-to-DRIVE edge. This gives the gate block at least TICK_DIV cycles of settling before capture.
- Table bits update at the end of the SAMPLE cycle and are visible the cycle after.
- Manual mode: SAMPLE occurs the cycle after step is seen.

## Structure
- Package sweep_pkg holds:
  - typedef enum logic [1:0] sweep_state_t {IDLE, DRIVE, SAMPLE, DONE};
  - localparam N_COMB = 8;
  - localparam IDX_W = 3.
- Counter width is $clog2(TICK_DIV) rounded up to a minimum of 1.
- One sub-module, sweep_timer, is natural: a loadable down-counter with enable. Its ports are load, en, and zero.
- The FSM and capture registers live in truth_table_sweeper.

## Test plan
- **Reset:** TICK_DIV=4; assert rst_n=0 mid-sweep at abc=3 → all outputs 0 and state IDLE immediately (asynchronously); start afterwards runs from abc=0.
- **Auto sweep:** TICK_DIV=4, with a behavioural gate model attached (x=(a&b)^~c, y1=a&b). Pulse start → done at cycle 41; x_table=8'h95, y_table=8'hC0; abc holds each value exactly 5 cycles.
- **Manual mode:** step_mode=1, start, then 8 step pulses spaced randomly 1–20 cycles apart → same tables. No advance occurs without step; done arrives one cycle after the SAMPLE for abc=7.
- **Ignored pulses:**
  - start while busy does not restart; abc continues unchanged.
  - step with step_mode=0 has no effect on timing.
- **Restart from DONE:** after a sweep with the model replaced by x_in=1, y_in=0 constant → tables FF/00; start again with the real model → tables cleared to 00 during the sweep, ending 95/C0.
- **Minimum dwell:** TICK_DIV=1 → sweep completes in 17 cycles after start with correct tables; mode toggled mid-sweep switches behaviour without skipping or repeating any abc value.
